// File: rtl/mbist_pkg.sv
// Shared types and constant tables for the MBIST stimulus generator.
//   - op_e         : single March operation (write/read of background or its inverse)
//   - march_elem_t : one March element (direction, op count, up to two ops)
//   - MARCH_C      : March C- element table, E0..E5
//   - BACKGROUNDS  : data backgrounds indexed by pattern number
//   - state_e      : sequencer FSM states
package mbist_pkg;

    typedef enum logic [1:0] {
        OP_W0,
        OP_W1,
        OP_R0,
        OP_R1
    } op_e;

    typedef struct packed {
        logic       dir_down;
        logic [1:0] num_ops;
        op_e        op0;
        op_e        op1;
    } march_elem_t;

    localparam int         NUM_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM = 3'd5;
    localparam logic [1:0] LAST_PAT  = 2'd3;

    // Single-op elements repeat op0 in op1; op1 is never issued for them.
    localparam march_elem_t MARCH_C [NUM_ELEMS] = '{
        '{1'b0, 2'd1, OP_W0, OP_W0},
        '{1'b0, 2'd2, OP_R0, OP_W1},
        '{1'b0, 2'd2, OP_R1, OP_W0},
        '{1'b1, 2'd2, OP_R0, OP_W1},
        '{1'b1, 2'd2, OP_R1, OP_W0},
        '{1'b0, 2'd1, OP_R0, OP_R0}
    };

    localparam logic [31:0] BACKGROUNDS [4] = '{
        32'h0000_0000,
        32'h5555_5555,
        32'h3333_3333,
        32'h0F0F_0F0F
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic op_is_write(input op_e op);
        return (op == OP_W0) || (op == OP_W1);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March sequencer.
//   load/load_down : reload with the start address of an up (START) or down (END) sweep
//   step/step_down : advance one address in the given direction (load has priority)
//   addr           : current address
//   at_start/at_end: terminal flags, exact compare so the counter never wraps
module mbist_addr_gen #(
    parameter int                  ADDR_WD    = 9,
    parameter logic [ADDR_WD-1:0]  ADDR_START = '0,
    parameter logic [ADDR_WD-1:0]  ADDR_END   = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               load_down,
    input  logic               step,
    input  logic               step_down,
    output logic [ADDR_WD-1:0] addr,
    output logic               at_start,
    output logic               at_end
);

    logic [ADDR_WD-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? ADDR_END : ADDR_START;
        end else if (step) begin
            addr_d = step_down ? (addr_q - ADDR_WD'(1)) : (addr_q + ADDR_WD'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= ADDR_START;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign at_start = (addr_q == ADDR_START);
    assign at_end   = (addr_q == ADDR_END);

endmodule

// File: rtl/mbist_stim_gen.sv
// MBIST stimulus generator: runs March C- over [START..END] for four data
// backgrounds, drives the SRAM command port and issues delay-aligned compare
// controls to the data comparator.
//   clk, rst_n            : clock, async active-low reset
//   bist_run, bist_error  : start/hold level, comparator abort request
//   mem_*                 : registered SRAM command (one op per cycle in RUN)
//   compare, comp_data, read_invert, cmp_addr, addr_inc_phase
//                         : read expectations delayed by BIST_RD_LAT cycles
//   bist_done, bist_fail  : completion status, held until bist_run drops
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | counters cleared, waiting for bist_run
// ST_RUN   | one March op issued per cycle
// ST_DRAIN | no commands, waiting BIST_RD_LAT cycles for in-flight compares
// ST_DONE  | bist_done (and possibly bist_fail) held until bist_run=0
module mbist_stim_gen
    import mbist_pkg::*;
#(
    parameter int                      BIST_ADDR_WD    = 9,
    parameter int                      BIST_DATA_WD    = 32,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
    parameter int                      BIST_RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bist_run,
    input  logic                    bist_error,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [BIST_ADDR_WD-1:0] mem_addr,
    output logic [BIST_DATA_WD-1:0] mem_wdata,
    output logic                    compare,
    output logic [BIST_DATA_WD-1:0] comp_data,
    output logic                    read_invert,
    output logic [BIST_ADDR_WD-1:0] cmp_addr,
    output logic                    addr_inc_phase,
    output logic                    bist_done,
    output logic                    bist_fail
);

    state_e                  state_q, state_d;
    logic [1:0]              pat_q, pat_d;
    logic [2:0]              elem_q, elem_d;
    logic                    op_q, op_d;
    logic [1:0]              drain_q, drain_d;
    logic                    abort_q, abort_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;

    // Registered command stage; bg/inv/last ride along to feed the compare pipe.
    logic                    cs_q, cs_d;
    logic                    we_q, we_d;
    logic [BIST_ADDR_WD-1:0] addr_q, addr_d;
    logic [BIST_DATA_WD-1:0] wdata_q, wdata_d;
    logic [BIST_DATA_WD-1:0] bg_q, bg_d;
    logic                    inv_q, inv_d;
    logic                    last_q, last_d;

    logic [BIST_RD_LAT-1:0]  pv_q, pv_d, pi_q, pi_d, pl_q, pl_d;
    logic [BIST_DATA_WD-1:0] pd_q [BIST_RD_LAT];
    logic [BIST_DATA_WD-1:0] pd_d [BIST_RD_LAT];
    logic [BIST_ADDR_WD-1:0] pa_q [BIST_RD_LAT];
    logic [BIST_ADDR_WD-1:0] pa_d [BIST_RD_LAT];

    logic                    ag_load, ag_load_down, ag_step;
    logic [BIST_ADDR_WD-1:0] ag_addr;
    logic                    ag_at_start, ag_at_end;

    march_elem_t             cur_elem;
    op_e                     cur_op;
    logic                    last_op, at_term;
    logic [BIST_DATA_WD-1:0] bg;

    assign cur_elem = MARCH_C[elem_q];
    assign cur_op   = op_q ? cur_elem.op1 : cur_elem.op0;
    assign last_op  = (cur_elem.num_ops == 2'd1) || op_q;
    assign at_term  = cur_elem.dir_down ? ag_at_start : ag_at_end;
    assign bg       = BIST_DATA_WD'(BACKGROUNDS[pat_q]);

    mbist_addr_gen #(
        .ADDR_WD    (BIST_ADDR_WD),
        .ADDR_START (BIST_ADDR_START),
        .ADDR_END   (BIST_ADDR_END)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .step_down (cur_elem.dir_down),
        .addr      (ag_addr),
        .at_start  (ag_at_start),
        .at_end    (ag_at_end)
    );

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        elem_d       = elem_q;
        op_d         = op_q;
        drain_d      = drain_q;
        abort_d      = abort_q;
        done_d       = done_q;
        fail_d       = fail_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bg_d         = bg_q;
        inv_d        = inv_q;
        last_d       = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bist_run && !done_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bist_run) begin
                    state_d = ST_IDLE;
                end else if (bist_error) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'(BIST_RD_LAT - 1);
                    abort_d = 1'b1;
                end else begin
                    cs_d   = 1'b1;
                    we_d   = op_is_write(cur_op);
                    addr_d = ag_addr;
                    bg_d   = bg;
                    inv_d  = (cur_op == OP_W1) || (cur_op == OP_R1);
                    last_d = last_op;
                    if (op_is_write(cur_op)) wdata_d = (cur_op == OP_W1) ? ~bg : bg;

                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!at_term) begin
                            ag_step = 1'b1;
                        end else if (elem_q != LAST_ELEM) begin
                            elem_d       = elem_q + 3'd1;
                            ag_load      = 1'b1;
                            ag_load_down = MARCH_C[elem_q + 3'd1].dir_down;
                        end else if (pat_q != LAST_PAT) begin
                            pat_d        = pat_q + 2'd1;
                            elem_d       = 3'd0;
                            ag_load      = 1'b1;
                            ag_load_down = MARCH_C[0].dir_down;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = 2'(BIST_RD_LAT - 1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!bist_run) begin
                    state_d = ST_IDLE;
                end else if (drain_q == 2'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fail_d  = abort_q || bist_error;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            ST_DONE: begin
                if (!bist_run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every path into IDLE restarts the test from pattern 0, E0, START.
        if (state_d == ST_IDLE) begin
            pat_d        = 2'd0;
            elem_d       = 3'd0;
            op_d         = 1'b0;
            drain_d      = 2'd0;
            abort_d      = 1'b0;
            done_d       = 1'b0;
            fail_d       = 1'b0;
            ag_load      = 1'b1;
            ag_load_down = 1'b0;
        end
    end

    // Compare pipe is fed from the registered command so that stage
    // BIST_RD_LAT-1 lines up with the SRAM read data.
    always_comb begin
        pv_d = pv_q;
        pi_d = pi_q;
        pl_d = pl_q;
        pd_d = pd_q;
        pa_d = pa_q;
        for (int i = BIST_RD_LAT - 1; i > 0; i--) begin
            pv_d[i] = pv_q[i-1];
            pi_d[i] = pi_q[i-1];
            pl_d[i] = pl_q[i-1];
            pd_d[i] = pd_q[i-1];
            pa_d[i] = pa_q[i-1];
        end
        pv_d[0] = cs_q & ~we_q;
        pi_d[0] = inv_q;
        pl_d[0] = cs_q & last_q;
        pd_d[0] = bg_q;
        pa_d[0] = addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= 2'd0;
            elem_q  <= 3'd0;
            op_q    <= 1'b0;
            drain_q <= 2'd0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bg_q    <= '0;
            inv_q   <= 1'b0;
            last_q  <= 1'b0;
            pv_q    <= '0;
            pi_q    <= '0;
            pl_q    <= '0;
            for (int i = 0; i < BIST_RD_LAT; i++) begin
                pd_q[i] <= '0;
                pa_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            drain_q <= drain_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bg_q    <= bg_d;
            inv_q   <= inv_d;
            last_q  <= last_d;
            pv_q    <= pv_d;
            pi_q    <= pi_d;
            pl_q    <= pl_d;
            pd_q    <= pd_d;
            pa_q    <= pa_d;
        end
    end

    assign mem_cs         = cs_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign compare        = pv_q[BIST_RD_LAT-1];
    assign read_invert    = pi_q[BIST_RD_LAT-1];
    assign addr_inc_phase = pl_q[BIST_RD_LAT-1];
    assign comp_data      = pd_q[BIST_RD_LAT-1];
    assign cmp_addr       = pa_q[BIST_RD_LAT-1];
    assign bist_done      = done_q;
    assign bist_fail      = fail_q;

endmodule

// File: tb/tb_mbist_stim_gen.sv
// Self-checking bench for mbist_stim_gen (4 addresses, read latency 2).
// The reference model expands March C- into a flat list of operations; the
// expected command at cycle c (c = posedges after bist_run is raised) is list
// entry c-2, its compare appears LAT cycles later, and bist_done rises LAT
// cycles after the FSM leaves RUN.
module tb_mbist_stim_gen;

    localparam int            AW      = 4;
    localparam int            DW      = 32;
    localparam int            LAT     = 2;
    localparam logic [AW-1:0] A_START = 4'd0;
    localparam logic [AW-1:0] A_END   = 4'd3;
    localparam int            NADDR   = 4;
    localparam int            MAXN    = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bist_run = 1'b0;
    logic          bist_error = 1'b0;
    logic          mem_cs, mem_we, compare, read_invert, addr_inc_phase, bist_done, bist_fail;
    logic [AW-1:0] mem_addr, cmp_addr;
    logic [DW-1:0] mem_wdata, comp_data;

    int n_cmp = 0;
    int n_bad = 0;

    // March C- in plain numbers: op codes 0=w0 1=w1 2=r0 3=r1.
    int el_up   [6] = '{1, 1, 1, 0, 0, 1};
    int el_nops [6] = '{1, 2, 2, 2, 2, 1};
    int el_op0  [6] = '{0, 2, 3, 2, 3, 2};
    int el_op1  [6] = '{0, 1, 0, 1, 0, 2};
    logic [31:0] bgs [4] = '{32'h0000_0000, 32'h5555_5555, 32'h3333_3333, 32'h0F0F_0F0F};

    int            m_n;
    int            m_reads;
    logic          m_we   [MAXN];
    logic          m_rd   [MAXN];
    logic          m_inv  [MAXN];
    logic          m_last [MAXN];
    logic [AW-1:0] m_addr [MAXN];
    logic [DW-1:0] m_wdata[MAXN];
    logic [DW-1:0] m_bg   [MAXN];

    mbist_stim_gen #(
        .BIST_ADDR_WD    (AW),
        .BIST_DATA_WD    (DW),
        .BIST_ADDR_START (A_START),
        .BIST_ADDR_END   (A_END),
        .BIST_RD_LAT     (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bist_run       (bist_run),
        .bist_error     (bist_error),
        .mem_cs         (mem_cs),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .compare        (compare),
        .comp_data      (comp_data),
        .read_invert    (read_invert),
        .cmp_addr       (cmp_addr),
        .addr_inc_phase (addr_inc_phase),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void build_model();
        int code, a;
        m_n = 0;
        m_reads = 0;
        for (int p = 0; p < 4; p++)
            for (int e = 0; e < 6; e++)
                for (int i = 0; i < NADDR; i++) begin
                    a = (el_up[e] != 0) ? int'(A_START) + i : int'(A_END) - i;
                    for (int o = 0; o < el_nops[e]; o++) begin
                        code = (o == 0) ? el_op0[e] : el_op1[e];
                        m_we[m_n]    = (code < 2);
                        m_rd[m_n]    = (code >= 2);
                        m_inv[m_n]   = (code == 1) || (code == 3);
                        m_addr[m_n]  = AW'(a);
                        m_bg[m_n]    = bgs[p];
                        m_wdata[m_n] = (code == 1) ? ~bgs[p] : bgs[p];
                        m_last[m_n]  = (o == el_nops[e] - 1);
                        if (code >= 2) m_reads++;
                        m_n++;
                    end
                end
    endfunction

    // err_cyc: cycle during which bist_error is held (0 = never).
    // stop_cyc: cycle after which bist_run is dropped (0 = never).
    task automatic run_march(input int err_cyc, input int stop_cyc, output int pulses);
        int  last_cmd_cyc, drain_cyc, k, kc;
        bit  abort, late, cv, exp_cmp, exp_aip, exp_done, exp_fail;
        abort = (err_cyc >= 2) && (err_cyc <= m_n);
        late  = (err_cyc == m_n + LAT);
        if (stop_cyc > 0)  last_cmd_cyc = stop_cyc;
        else if (abort)    last_cmd_cyc = err_cyc;
        else               last_cmd_cyc = m_n + 1;
        drain_cyc = abort ? err_cyc + 1 : m_n + 1;
        pulses = 0;
        @(negedge clk);
        bist_run   = 1'b1;
        bist_error = 1'b0;
        for (int c = 1; c <= m_n + LAT + 4; c++) begin
            @(negedge clk);
            k  = c - 2;
            cv = (k >= 0) && (k < m_n) && (c <= last_cmd_cyc);
            n_cmp++;
            if (mem_cs !== cv) begin
                n_bad++;
                $display("FAIL mem_cs cyc=%0d got=%0b exp=%0b", c, mem_cs, cv);
            end
            if (cv) begin
                n_cmp++;
                if (mem_we !== m_we[k]) begin
                    n_bad++;
                    $display("FAIL mem_we cyc=%0d got=%0b exp=%0b", c, mem_we, m_we[k]);
                end
                n_cmp++;
                if (mem_addr !== m_addr[k]) begin
                    n_bad++;
                    $display("FAIL mem_addr cyc=%0d got=%0h exp=%0h", c, mem_addr, m_addr[k]);
                end
                if (m_we[k]) begin
                    n_cmp++;
                    if (mem_wdata !== m_wdata[k]) begin
                        n_bad++;
                        $display("FAIL mem_wdata cyc=%0d got=%0h exp=%0h", c, mem_wdata, m_wdata[k]);
                    end
                end
            end
            kc = c - LAT - 2;
            exp_cmp = 1'b0;
            exp_aip = 1'b0;
            if ((kc >= 0) && (kc < m_n) && (c - LAT <= last_cmd_cyc)) begin
                exp_cmp = m_rd[kc];
                exp_aip = m_last[kc];
            end
            if ((stop_cyc == 0) || (c <= stop_cyc)) begin
                n_cmp++;
                if (compare !== exp_cmp) begin
                    n_bad++;
                    $display("FAIL compare cyc=%0d got=%0b exp=%0b", c, compare, exp_cmp);
                end
                n_cmp++;
                if (addr_inc_phase !== exp_aip) begin
                    n_bad++;
                    $display("FAIL addr_inc_phase cyc=%0d got=%0b exp=%0b", c, addr_inc_phase, exp_aip);
                end
                if (exp_cmp) begin
                    n_cmp++;
                    if (comp_data !== m_bg[kc]) begin
                        n_bad++;
                        $display("FAIL comp_data cyc=%0d got=%0h exp=%0h", c, comp_data, m_bg[kc]);
                    end
                    n_cmp++;
                    if (read_invert !== m_inv[kc]) begin
                        n_bad++;
                        $display("FAIL read_invert cyc=%0d got=%0b exp=%0b", c, read_invert, m_inv[kc]);
                    end
                    n_cmp++;
                    if (cmp_addr !== m_addr[kc]) begin
                        n_bad++;
                        $display("FAIL cmp_addr cyc=%0d got=%0h exp=%0h", c, cmp_addr, m_addr[kc]);
                    end
                end
            end
            if (compare === 1'b1) pulses++;
            exp_done = (stop_cyc == 0) && (c >= drain_cyc + LAT);
            exp_fail = exp_done && (abort || late);
            n_cmp++;
            if (bist_done !== exp_done) begin
                n_bad++;
                $display("FAIL bist_done cyc=%0d got=%0b exp=%0b", c, bist_done, exp_done);
            end
            n_cmp++;
            if (bist_fail !== exp_fail) begin
                n_bad++;
                $display("FAIL bist_fail cyc=%0d got=%0b exp=%0b", c, bist_fail, exp_fail);
            end
            bist_error = (c == err_cyc);
            if ((stop_cyc > 0) && (c == stop_cyc)) bist_run = 1'b0;
        end
        bist_error = 1'b0;
    endtask

    task automatic release_run(input string tag);
        @(negedge clk);
        bist_run = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bist_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done_clear got=%0b exp=0", tag, bist_done);
        end
        n_cmp++;
        if (bist_fail !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_fail_clear got=%0b exp=0", tag, bist_fail);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_cs, mem_we, compare, read_invert, addr_inc_phase, bist_done, bist_fail} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {mem_cs, mem_we, compare, read_invert, addr_inc_phase, bist_done, bist_fail});
        end
        n_cmp++;
        if ({mem_addr, cmp_addr, mem_wdata, comp_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got=%0h exp=0", {mem_addr, cmp_addr, mem_wdata, comp_data});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ((mem_cs !== 1'b0) || (bist_done !== 1'b0)) begin
            n_bad++;
            $display("FAIL idle_after_reset cs=%0b done=%0b exp=0", mem_cs, bist_done);
        end
    endtask

    task automatic test_pass_run();
        int pulses;
        run_march(0, 0, pulses);
        n_cmp++;
        if (pulses !== m_reads) begin
            n_bad++;
            $display("FAIL pass_compare_count got=%0d exp=%0d", pulses, m_reads);
        end
        release_run("pass");
    endtask

    task automatic test_abort();
        int pulses, ec;
        ec = int'($urandom_range(2, m_n));
        run_march(ec, 0, pulses);
        release_run("abort");
    endtask

    task automatic test_drain_error();
        int pulses;
        run_march(m_n + LAT, 0, pulses);
        release_run("drain_err");
    endtask

    task automatic test_stop_restart();
        int pulses, sc;
        sc = int'($urandom_range(3, m_n - 1));
        run_march(0, sc, pulses);
        run_march(0, 0, pulses);
        n_cmp++;
        if (pulses !== m_reads) begin
            n_bad++;
            $display("FAIL restart_compare_count got=%0d exp=%0d", pulses, m_reads);
        end
        release_run("restart");
    endtask

    initial begin
        build_model();
        test_reset();
        test_pass_run();
        test_abort();
        test_abort();
        test_drain_error();
        test_stop_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
